// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler: the decoded packet handed from
// decode through the issue queue to the two ALU lanes.
package dual_issue_scheduler_pkg;

    localparam int         PKT_DW   = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              RegWrite;
        logic              UsesRs1;
        logic              UsesRs2;
        logic              Solo;
        logic [3:0]        ALUCtrl;
        logic              ALUSrcB;
        logic [PKT_DW-1:0] RD1;
        logic [PKT_DW-1:0] RD2;
        logic [PKT_DW-1:0] ImmExt;
    } issue_pkt_t;

endpackage

// File: rtl/dual_issue_scheduler_pair_check.sv
// Decides whether two adjacent queue entries may issue together: neither is
// Solo and the younger has no RAW/WAW hazard on the older's destination.
module issue_pair_check
    import dual_issue_scheduler_pkg::*;
(
    input  issue_pkt_t older,
    input  issue_pkt_t younger,
    output logic       pair_ok
);

    logic raw;
    logic waw;

    always_comb begin
        raw = older.RegWrite && (older.rd != REG_ZERO) &&
              ((younger.UsesRs1 && (younger.rs1 == older.rd)) ||
               (younger.UsesRs2 && (younger.rs2 == older.rd)));
        waw = older.RegWrite && younger.RegWrite &&
              (older.rd != REG_ZERO) && (older.rd == younger.rd);
        pair_ok = !older.Solo && !younger.Solo && !raw && !waw;
    end

    // Fields that play no part in hazard detection.
    logic unused_fields;
    assign unused_fields = ^{older.rs1, older.rs2, older.UsesRs1, older.UsesRs2,
                             older.ALUCtrl, older.ALUSrcB, older.RD1, older.RD2, older.ImmExt,
                             younger.ALUCtrl, younger.ALUSrcB, younger.RD1, younger.RD2,
                             younger.ImmExt};

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order issue queue feeding two ALU lanes; the oldest entry goes to lane A
// and the next one joins it in lane B when the pair is hazard-free.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  InValid_i,
    input  issue_pkt_t  InPkt0_i,
    input  issue_pkt_t  InPkt1_i,
    output logic        InReady_o,
    input  logic        Stall_i,
    input  logic        Flush_i,
    output logic        IssueValidA_o,
    output logic        IssueValidB_o,
    output issue_pkt_t  IssuePktA_o,
    output issue_pkt_t  IssuePktB_o,
    output logic [31:0] DualCount_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DATA_WIDTH != PKT_DW) begin : g_dw_mismatch
        $error("DATA_WIDTH must match the packet operand width");
    end

    issue_pkt_t      mem [DEPTH];
    logic [PW-1:0]   head, tail, head_nxt, tail_nxt;
    logic [CW-1:0]   count, n_push, n_pop;
    logic            push_ok, issue_a, issue_b, pair_ok;
    issue_pkt_t      head_pkt, next_pkt;

    assign head_nxt  = head + PW'(1);
    assign tail_nxt  = tail + PW'(1);
    assign head_pkt  = mem[head];
    assign next_pkt  = mem[head_nxt];
    // Readiness looks only at the registered count, never at this cycle's pops.
    assign InReady_o = (count <= CW'(DEPTH - 2));

    issue_pair_check u_pair_check (
        .older   (head_pkt),
        .younger (next_pkt),
        .pair_ok (pair_ok)
    );

    always_comb begin
        push_ok = InReady_o && !Flush_i;
        n_push  = '0;
        if (push_ok && (InValid_i == 2'b01))
            n_push = CW'(1);
        else if (push_ok && (InValid_i == 2'b11))
            n_push = CW'(2);
        issue_a = !Stall_i && (count != '0);
        issue_b = issue_a && (count >= CW'(2)) && pair_ok;
        n_pop   = CW'(issue_a) + CW'(issue_b);
    end

    always_ff @(posedge clk_i) begin
        if (n_push != '0)
            mem[tail] <= InPkt0_i;
        if (n_push == CW'(2))
            mem[tail_nxt] <= InPkt1_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (Flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_pop);
            tail  <= tail + PW'(n_push);
            count <= count + n_push - n_pop;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            IssueValidA_o <= 1'b0;
            IssueValidB_o <= 1'b0;
            IssuePktA_o   <= '0;
            IssuePktB_o   <= '0;
            DualCount_o   <= '0;
        end else if (Flush_i) begin
            IssueValidA_o <= 1'b0;
            IssueValidB_o <= 1'b0;
            IssuePktA_o   <= '0;
            IssuePktB_o   <= '0;
        end else if (!Stall_i) begin
            IssueValidA_o <= issue_a;
            IssueValidB_o <= issue_b;
            IssuePktA_o   <= issue_a ? head_pkt : '0;
            IssuePktB_o   <= issue_b ? next_pkt : '0;
            if (issue_b)
                DualCount_o <= DualCount_o + 32'd1;
        end
    end

endmodule
